// File: rtl/fns_cfg_scheduler_pkg.sv
// fns_cfg_scheduler_pkg: shared defaults, FSM state type and reference weights.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fns_cfg_scheduler_pkg;

  // Default geometry of the 9-TSV FNS coder.
  localparam int FNS_N_TSV  = 9;
  localparam int FNS_WGT_W  = 7;
  localparam int FNS_DATA_W = 7;

  // Weights produced when every TSV is enabled (Fibonacci 1,1,2,3,...).
  localparam int FNS_REF_WGT [FNS_N_TSV] = '{1, 1, 2, 3, 5, 8, 13, 21, 34};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no configuration committed yet
    ST_CALC  = 2'd1,  // weights being recomputed
    ST_READY = 2'd2   // configuration valid, data may flow
  } sched_state_t;

endpackage

// File: rtl/fns_cfg_scheduler_if.sv
// fns_cfg_scheduler_if: config request, committed coder settings and data handshake.
// Latency: n/a (wires only).
// Backpressure: cfg_ready / in_ready driven by the scheduler (slave side).
// Ports: cfg_valid/cfg_mask/cfg_ready, busy, done, en_flag, wgt_flat, cap_max,
//        in_valid/in_data/in_ready, out_valid/out_data, range_err.
interface fns_cfg_scheduler_if
  import fns_cfg_scheduler_pkg::*;
#(
  parameter int N_TSV  = FNS_N_TSV,
  parameter int WGT_W  = FNS_WGT_W,
  parameter int DATA_W = FNS_DATA_W
);
  logic                     cfg_valid;
  logic [N_TSV-1:0]         cfg_mask;
  logic                     cfg_ready;
  logic                     busy;
  logic                     done;
  logic [N_TSV-1:0]         en_flag;
  logic [N_TSV*WGT_W-1:0]   wgt_flat;
  logic [WGT_W-1:0]         cap_max;
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     range_err;

  // Fault-management / data source side.
  modport master (
    output cfg_valid, cfg_mask, in_valid, in_data,
    input  cfg_ready, busy, done, en_flag, wgt_flat, cap_max,
           in_ready, out_valid, out_data, range_err
  );

  // Scheduler side.
  modport slave (
    input  cfg_valid, cfg_mask, in_valid, in_data,
    output cfg_ready, busy, done, en_flag, wgt_flat, cap_max,
           in_ready, out_valid, out_data, range_err
  );
endinterface

// File: rtl/fns_cfg_scheduler_weight_iter.sv
// fns_weight_iter: iterative Fibonacci weight builder, one TSV index per cycle.
// Latency: N_TSV cycles from start_i; done_o is high during the last index cycle.
// Backpressure: none; start_i is only honoured by the caller when idle.
// Ports: clock, reset, start_i, mask_i -> done_o, wgt_o (flat, final value
//        of the current index merged in), sum_o (running sum incl. current index).
module fns_weight_iter #(
  parameter int N_TSV = 9,
  parameter int WGT_W = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [N_TSV-1:0]       mask_i,
  output logic                   done_o,
  output logic [N_TSV*WGT_W-1:0] wgt_o,
  output logic [WGT_W-1:0]       sum_o
);
  localparam int IDX_W = (N_TSV > 1) ? $clog2(N_TSV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TSV - 1);

  logic                 active_q;
  logic [IDX_W-1:0]     idx_q;
  logic [N_TSV-1:0]     mask_q;
  logic [WGT_W-1:0]     fib_prev_q;
  logic [WGT_W-1:0]     fib_cur_q;
  logic [WGT_W-1:0]     acc_q;
  logic [WGT_W-1:0]     work_w_q [N_TSV];

  logic                 take;
  logic [WGT_W-1:0]     step_w;

  assign take   = mask_q[idx_q];
  assign step_w = take ? fib_cur_q : '0;
  assign done_o = active_q && (idx_q == IDX_LAST);
  // Include the current step so the caller can commit in the same edge.
  assign sum_o  = acc_q + step_w;

  always_comb begin
    wgt_o = '0;
    for (int i = 0; i < N_TSV; i++) begin
      if (active_q && (idx_q == IDX_W'(i)))
        wgt_o[i*WGT_W +: WGT_W] = step_w;
      else
        wgt_o[i*WGT_W +: WGT_W] = work_w_q[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || start_i) begin
      active_q   <= start_i && !reset;
      idx_q      <= '0;
      mask_q     <= reset ? '0 : mask_i;
      fib_prev_q <= '0;
      fib_cur_q  <= WGT_W'(1);
      acc_q      <= '0;
      for (int i = 0; i < N_TSV; i++) work_w_q[i] <= '0;
    end else if (active_q) begin
      work_w_q[idx_q] <= step_w;
      acc_q           <= sum_o;
      // Disabled TSVs do not consume a Fibonacci term.
      if (take) begin
        fib_prev_q <= fib_cur_q;
        fib_cur_q  <= fib_cur_q + fib_prev_q;
      end
      if (done_o) active_q <= 1'b0;
      else        idx_q    <= idx_q + IDX_W'(1);
    end
  end
endmodule

// File: rtl/fns_cfg_scheduler.sv
// fns_cfg_scheduler: accepts a TSV mask, builds Fibonacci weights, commits them
//   atomically to the FNS coder and gates coder input data with a range check.
// Latency: config commit N_TSV cycles after fire (done one cycle later); data 1 cycle.
// Backpressure: cfg_ready low in CALC; in_ready low unless READY and no cfg_valid.
// Ports: clock, reset (sync, active-high), bus (slave modport of fns_cfg_scheduler_if).
module fns_cfg_scheduler
  import fns_cfg_scheduler_pkg::*;
#(
  parameter int N_TSV  = FNS_N_TSV,
  parameter int WGT_W  = FNS_WGT_W,
  parameter int DATA_W = FNS_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  fns_cfg_scheduler_if.slave  bus
);
  localparam int CMP_W = (WGT_W > DATA_W) ? WGT_W : DATA_W;

  sched_state_t           state_q;
  logic                   busy_q;
  logic                   done_q;
  logic [N_TSV-1:0]       pend_mask_q;
  logic [N_TSV-1:0]       en_q;
  logic [N_TSV*WGT_W-1:0] wgt_q;
  logic [WGT_W-1:0]       cap_q;
  logic                   out_valid_q;
  logic [DATA_W-1:0]      out_data_q;
  logic                   range_err_q;

  logic                   cfg_rdy;
  logic                   in_rdy;
  logic                   cfg_fire;
  logic                   data_acc;
  logic                   in_range;
  logic                   iter_done;
  logic [N_TSV*WGT_W-1:0] iter_wgt;
  logic [WGT_W-1:0]       iter_sum;

  assign cfg_rdy  = (state_q != ST_CALC);
  // A pending config request blocks data in the same cycle.
  assign in_rdy   = (state_q == ST_READY) && !bus.cfg_valid;
  assign cfg_fire = bus.cfg_valid && cfg_rdy;
  assign data_acc = bus.in_valid && in_rdy;
  assign in_range = CMP_W'(bus.in_data) <= CMP_W'(cap_q);

  fns_weight_iter #(.N_TSV(N_TSV), .WGT_W(WGT_W)) u_iter (
    .clock   (clock),
    .reset   (reset),
    .start_i (cfg_fire),
    .mask_i  (bus.cfg_mask),
    .done_o  (iter_done),
    .wgt_o   (iter_wgt),
    .sum_o   (iter_sum)
  );

  // FSM plus commit registers; committed outputs only change on the final
  // CALC edge so the coder never sees a half-built weight set.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_mask_q <= '0;
      en_q        <= '0;
      wgt_q       <= '0;
      cap_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (cfg_fire) begin
            state_q     <= ST_CALC;
            busy_q      <= 1'b1;
            pend_mask_q <= bus.cfg_mask;
          end
        end
        ST_CALC: begin
          if (iter_done) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            en_q    <= pend_mask_q;
            wgt_q   <= iter_wgt;
            cap_q   <= iter_sum;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Data path: out_data holds its last passed word when nothing is emitted.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      range_err_q <= 1'b0;
    end else if (data_acc && in_range) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data;
      range_err_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      range_err_q <= data_acc;  // accepted but over capacity: dropped
    end
  end

  assign bus.cfg_ready = cfg_rdy;
  assign bus.in_ready  = in_rdy;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.en_flag   = en_q;
  assign bus.wgt_flat  = wgt_q;
  assign bus.cap_max   = cap_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.range_err = range_err_q;
endmodule

// File: tb/tb_fns_cfg_scheduler.sv
// tb_fns_cfg_scheduler: directed and randomized bench for fns_cfg_scheduler.
// Latency: n/a.
// Backpressure: n/a.
module tb_fns_cfg_scheduler;
  import fns_cfg_scheduler_pkg::*;

  localparam int N = 9;
  localparam int W = 7;
  localparam int D = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fns_cfg_scheduler_if #(.N_TSV(N), .WGT_W(W), .DATA_W(D)) bus ();
  fns_cfg_scheduler #(.N_TSV(N), .WGT_W(W), .DATA_W(D)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: weights from the mask rule directly (k-th enabled TSV
  // gets the k-th term of 1,1,2,3,5,...), plus cycle counters for sequencing.
  bit           m_known = 0;
  int           m_left  = 0;
  bit           m_ready = 0;
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_en    = '0;
  int           m_w [N];
  int           m_cap   = 0;
  bit           e_busy, e_done, e_ov, e_err;
  int           e_od    = 0;
  int           n_acc   = 0;
  int           n_out   = 0;

  function automatic int fib_w(input logic [N-1:0] mask, input int i);
    int k, a, b, t;
    if (!mask[i]) return 0;
    k = 0;
    for (int j = 0; j < i; j++) if (mask[j]) k++;
    a = 1; b = 1;
    repeat (k) begin t = a + b; a = b; b = t; end
    return a;
  endfunction

  task automatic tick(input bit r, input bit cv, input logic [N-1:0] cm,
                      input bit iv, input logic [D-1:0] id);
    bit acc;
    rst = r; bus.cfg_valid = cv; bus.cfg_mask = cm; bus.in_valid = iv; bus.in_data = id;
    #1;
    acc = iv && m_ready && !cv && (m_left == 0);
    if (m_known) begin
      chk("cfg_ready", bus.cfg_ready, m_left == 0);
      chk("in_ready", bus.in_ready, m_ready && !cv && (m_left == 0));
    end
    if (r) begin
      m_known = 1; m_left = 0; m_ready = 0; m_en = '0; m_cap = 0;
      for (int i = 0; i < N; i++) m_w[i] = 0;
      e_busy = 0; e_done = 0; e_ov = 0; e_err = 0; e_od = 0;
    end else begin
      e_ov = 0; e_err = 0;
      if (acc) begin
        n_acc++;
        if (int'(id) <= m_cap) begin e_ov = 1; e_od = int'(id); end
        else e_err = 1;
      end
      e_done = (m_left == 1);
      if (m_left == 1) begin
        m_en = m_pend; m_cap = 0;
        for (int i = 0; i < N; i++) begin m_w[i] = fib_w(m_pend, i); m_cap += m_w[i]; end
        m_ready = 1; m_left = 0;
      end else if (m_left > 0) begin
        m_left--;
      end else if (cv) begin
        m_left = N; m_pend = cm;
      end
      e_busy = (m_left > 0);
    end
    @(posedge clk); #1;
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("out_valid", bus.out_valid, e_ov);
    chk("range_err", bus.range_err, e_err);
    chk("out_data", bus.out_data, e_od);
    chk("en_flag", bus.en_flag, m_en);
    chk("cap_max", bus.cap_max, m_cap);
    for (int i = 0; i < N; i++) chk("wgt", bus.wgt_flat[i*W +: W], m_w[i]);
    if (bus.out_valid || bus.range_err) n_out++;
  endtask

  // Wait for the done pulse (bounded), optionally streaming random data.
  task automatic wait_done(input bit stream, output int n);
    n = 1;
    while (!bus.done && n < 40) begin
      tick(1'b0, 1'b0, '0, stream && ($urandom_range(0, 3) != 0), D'($urandom_range(0, 127)));
      n++;
    end
    chk("done_seen", bus.done, 1);
  endtask

  initial begin
    int n;
    bit r, cv, iv;
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_cap", bus.cap_max, 0);

    // Full mask: done 10 cycles after fire, reference weights.
    tick(1'b0, 1'b1, 9'h1FF, 1'b0, '0);
    wait_done(1'b0, n);
    chk("done_latency", n, 10);
    for (int i = 0; i < N; i++) chk("ref_wgt", bus.wgt_flat[i*W +: W], FNS_REF_WGT[i]);
    chk("cap_full", bus.cap_max, 88);

    // One disabled TSV in the middle.
    tick(1'b0, 1'b1, 9'b111101111, 1'b0, '0);
    wait_done(1'b0, n);
    chk("cap_1ef", bus.cap_max, 54);
    chk("wgt4_off", bus.wgt_flat[4*W +: W], 0);
    chk("wgt8_1ef", bus.wgt_flat[8*W +: W], 21);
    tick(1'b0, 1'b0, '0, 1'b1, 7'd54);
    chk("pass54_valid", bus.out_valid, 1);
    chk("pass54_data", bus.out_data, 54);
    tick(1'b0, 1'b0, '0, 1'b1, 7'd55);
    chk("drop55_err", bus.range_err, 1);
    chk("drop55_valid", bus.out_valid, 0);

    // Stream, then reconfigure in the same cycle as a data word.
    repeat (6) tick(1'b0, 1'b0, '0, 1'b1, D'($urandom_range(0, 80)));
    tick(1'b0, 1'b1, 9'h0FF, 1'b1, 7'd7);
    chk("same_cyc_no_data", bus.out_valid, 0);
    chk("same_cyc_busy", bus.busy, 1);
    chk("old_cap_in_calc", bus.cap_max, 54);
    // Held request during CALC must be ignored.
    tick(1'b0, 1'b1, 9'h003, 1'b1, 7'd3);
    tick(1'b0, 1'b1, 9'h003, 1'b1, 7'd3);
    wait_done(1'b1, n);
    chk("cap_0ff", bus.cap_max, 54);
    chk("en_0ff", bus.en_flag, 9'h0FF);

    // Reset during the 4th CALC cycle.
    tick(1'b0, 1'b1, 9'h1FF, 1'b0, '0);
    repeat (3) tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b1, 1'b0, '0, 1'b0, '0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cap", bus.cap_max, 0);
    chk("abort_wgt", bus.wgt_flat, 0);
    chk("abort_en", bus.en_flag, 0);
    chk("abort_cfg_ready", bus.cfg_ready, 1);
    tick(1'b0, 1'b0, '0, 1'b1, 7'd0);
    chk("idle_no_data", bus.out_valid, 0);
    chk("idle_no_done", bus.done, 0);

    // All-zero mask.
    tick(1'b0, 1'b1, 9'h000, 1'b0, '0);
    wait_done(1'b0, n);
    chk("cap_zero", bus.cap_max, 0);
    tick(1'b0, 1'b0, '0, 1'b1, 7'd0);
    chk("zero_pass", bus.out_valid, 1);
    tick(1'b0, 1'b0, '0, 1'b1, 7'd1);
    chk("one_err", bus.range_err, 1);

    // Randomized traffic against the model.
    repeat (500) begin
      r  = ($urandom_range(0, 149) == 0);
      cv = ($urandom_range(0, 11) == 0);
      iv = ($urandom_range(0, 3) != 0);
      tick(r, cv, N'($urandom), iv, D'($urandom_range(0, 127)));
    end
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    tick(1'b0, 1'b0, '0, 1'b0, '0);
    chk("words_conserved", n_out, n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
